// File: rtl/countdown_controller_pkg.sv
// Shared constants for the countdown controller: one-hot state bit positions,
// the state encoding and the default counter width.
package countdown_controller_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam int unsigned ST_T0 = 0;
  localparam int unsigned ST_T1 = 1;
  localparam int unsigned ST_T2 = 2;

  // One-hot encoding; each bit position doubles as the T0/T1/T2 output flag.
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_COUNT = 3'b010,
    S_DONE  = 3'b100
  } state_e;

endpackage

// File: rtl/countdown_controller_counter.sv
// Loadable down counter with synchronous clear; saturates at zero and reports
// zero / one so the controller can leave COUNT on the final decrement.
module load_down_counter
  import countdown_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic             clr,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count_reg;

  // Priority clr > load > dec; decrementing stops at zero so the count never wraps.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= D;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign Q    = count_reg;
  assign zero = (count_reg == '0);
  assign last = (count_reg == WIDTH'(1));

endmodule

// File: rtl/countdown_controller.sv
// Start/count/done controller: loads D on an accepted start, counts down to
// zero in COUNT, then waits in DONE until acknowledged.
module countdown_controller
  import countdown_controller_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             S,
  input  logic [WIDTH-1:0] D,
  input  logic             ack,
  input  logic             clr,
  output logic             T0,
  output logic             T1,
  output logic             T2,
  output logic             G,
  output logic             DONE,
  output logic [WIDTH-1:0] Q
);

  state_e     state_reg;
  logic [2:0] state_bits;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       cnt_last;

  assign state_bits = state_reg;
  assign cnt_load   = state_bits[ST_T0] & S;
  assign cnt_dec    = state_bits[ST_T1];

  load_down_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .CLK  (CLK),
    .reset(reset),
    .load (cnt_load),
    .dec  (cnt_dec),
    .clr  (clr),
    .D    (D),
    .Q    (Q),
    .zero (cnt_zero),
    .last (cnt_last)
  );

  // A zero load skips COUNT entirely; the zero guard in COUNT is only a safety net.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else if (clr) begin
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (S) begin
            state_reg <= (D == '0) ? S_DONE : S_COUNT;
          end
        end
        S_COUNT: begin
          if (cnt_last || cnt_zero) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign T0   = state_bits[ST_T0];
  assign T1   = state_bits[ST_T1];
  assign T2   = state_bits[ST_T2];
  assign G    = state_bits[ST_T1];
  assign DONE = state_bits[ST_T2];

endmodule
